// File: rtl/one_hot_seq_counter_if.sv
// Control and status bundle for one_hot_seq_counter; master drives the controls,
// slave is the counter itself.
interface one_hot_seq_counter_if #(
    parameter int N_OUT = 10,
    parameter int CNT_W = $clog2(N_OUT)
);
    logic             clock_inhibit;
    logic             up_dn;
    logic             one_shot;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [N_OUT-1:0] outputs;
    logic [CNT_W-1:0] count;
    logic             carry_out;
    logic             tc;
    logic             done;
    logic             load_err;

    modport master (
        output clock_inhibit, up_dn, one_shot, load, load_val,
        input  outputs, count, carry_out, tc, done, load_err
    );

    modport slave (
        input  clock_inhibit, up_dn, one_shot, load, load_val,
        output outputs, count, carry_out, tc, done, load_err
    );
endinterface

// File: rtl/one_hot_seq_counter.sv
// Parametrised one-hot sequence counter / divide-by-N with up/down, preset load,
// one-shot halt and a cascade terminal-count strobe.
module one_hot_seq_counter #(
    parameter int N_OUT       = 10,
    parameter int CARRY_SPLIT = N_OUT / 2,
    parameter int CNT_W       = $clog2(N_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    one_hot_seq_counter_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_OUT - 1);
    localparam logic [31:0]      N_OUT_U = 32'(N_OUT);
    localparam logic [31:0]      SPLIT_U = 32'(CARRY_SPLIT);

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic             load_err_q;
    logic [CNT_W-1:0] end_val;
    logic             at_end;
    logic             adv;
    logic             load_bad;

    always_comb begin
        end_val  = bus.up_dn ? LAST : '0;
        at_end   = (count_q == end_val);
        adv      = !bus.clock_inhibit && (state == RUN);
        load_bad = (32'(bus.load_val) >= N_OUT_U);
    end

    // Load beats advance and ignores inhibit/halt; an out-of-range preset lands on 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            if (bus.load) begin
                state <= RUN;
                if (load_bad) begin
                    count_q    <= '0;
                    load_err_q <= 1'b1;
                end else begin
                    count_q <= bus.load_val;
                end
            end else if (adv) begin
                if (!at_end) begin
                    count_q <= bus.up_dn ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
                end else if (bus.one_shot) begin
                    state <= HALT;
                end else begin
                    count_q <= bus.up_dn ? '0 : LAST;
                end
            end
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_decode
        assign bus.outputs[i] = (count_q == CNT_W'(i));
    end

    // tc depends only on registers and quasi-static controls, so it settles well before the next edge.
    assign bus.tc        = at_end && adv;
    assign bus.count     = count_q;
    assign bus.carry_out = (32'(count_q) < SPLIT_U);
    assign bus.done      = (state == HALT);
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_one_hot_seq_counter.sv
// Scoreboard bench for one_hot_seq_counter: a 10-output and a 4-output instance share
// stimulus and are checked against an arithmetic reference model.
module tb_one_hot_seq_counter;
    logic clk;
    logic reset;

    one_hot_seq_counter_if #(.N_OUT(10)) b10 ();
    one_hot_seq_counter_if #(.N_OUT(4))  b4 ();

    one_hot_seq_counter #(.N_OUT(10)) dut10 (.clk(clk), .reset(reset), .bus(b10.slave));
    one_hot_seq_counter #(.N_OUT(4), .CARRY_SPLIT(1)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

    typedef struct {
        int count;
        bit done;
        bit err;
    } mstate_t;

    typedef struct {
        int          count;
        logic [31:0] onehot;
        bit          carry;
        bit          tc;
        bit          done;
        bit          err;
    } exp_t;

    exp_t    q10[$];
    exp_t    q4[$];
    mstate_t s10;
    mstate_t s4;
    int      vectors;
    int      miscompares;
    bit      up_keep;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mstate_t reset_state();
        mstate_t r;
        r.count = 0;
        r.done  = 1'b0;
        r.err   = 1'b0;
        return r;
    endfunction

    function automatic exp_t observe(mstate_t s, int n, int split, bit inh, bit up);
        exp_t e;
        e.count  = s.count;
        e.onehot = 32'd1 << s.count;
        e.carry  = (s.count < split);
        e.tc     = !inh && !s.done && (s.count == (up ? n - 1 : 0));
        e.done   = s.done;
        e.err    = s.err;
        return e;
    endfunction

    // Effect of one clock edge on a counter of modulus n.
    function automatic mstate_t step(mstate_t s, int n, bit rst, bit inh, bit up, bit os,
                                     bit ld, int val);
        mstate_t r;
        int      last;
        r     = s;
        r.err = 1'b0;
        last  = up ? n - 1 : 0;
        if (rst) begin
            r = reset_state();
        end else if (ld) begin
            r.done = 1'b0;
            if (val < n) r.count = val;
            else begin
                r.count = 0;
                r.err   = 1'b1;
            end
        end else if (!inh && !s.done) begin
            if (s.count != last) r.count = up ? s.count + 1 : s.count - 1;
            else if (os) r.done = 1'b1;
            else r.count = up ? 0 : n - 1;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input exp_t e, input int a_count,
                                input logic [31:0] a_oh, input bit a_carry, input bit a_tc,
                                input bit a_done, input bit a_err);
        vectors++;
        if (a_count !== e.count || a_oh !== e.onehot || a_carry !== e.carry ||
            a_tc !== e.tc || a_done !== e.done || a_err !== e.err) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t: got count=%0d oh=%h carry=%b tc=%b done=%b err=%b, expected count=%0d oh=%h carry=%b tc=%b done=%b err=%b",
                     name, $time, a_count, a_oh, a_carry, a_tc, a_done, a_err,
                     e.count, e.onehot, e.carry, e.tc, e.done, e.err);
        end
    endtask

    // Drive one cycle shortly after the edge, queue what both counters should show
    // before the next edge, then advance the model across that edge.
    task automatic apply_stimulus(input bit rst, input bit inh, input bit up, input bit os,
                                  input bit ld, input int val);
        @(posedge clk);
        #2;
        reset            = rst;
        b10.clock_inhibit = inh;
        b10.up_dn        = up;
        b10.one_shot     = os;
        b10.load         = ld;
        b10.load_val     = 4'(val);
        b4.clock_inhibit = inh;
        b4.up_dn         = up;
        b4.one_shot      = os;
        b4.load          = ld;
        b4.load_val      = 2'(val);
        if (rst) begin
            s10 = reset_state();
            s4  = reset_state();
        end
        q10.push_back(observe(s10, 10, 5, inh, up));
        q4.push_back(observe(s4, 4, 1, inh, up));
        s10 = step(s10, 10, rst, inh, up, os, ld, val & 15);
        s4  = step(s4, 4, rst, inh, up, os, ld, val & 3);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q10.size() > 0) begin
                e = q10.pop_front();
                check_output("n10", e, int'(b10.count), 32'(b10.outputs), b10.carry_out,
                             b10.tc, b10.done, b10.load_err);
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check_output("n4", e, int'(b4.count), 32'(b4.outputs), b4.carry_out,
                             b4.tc, b4.done, b4.load_err);
            end
        end
    end

    initial begin : driver
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b1;
        b10.clock_inhibit = 1'b0;
        b10.up_dn         = 1'b1;
        b10.one_shot      = 1'b0;
        b10.load          = 1'b0;
        b10.load_val      = '0;
        b4.clock_inhibit  = 1'b0;
        b4.up_dn          = 1'b1;
        b4.one_shot       = 1'b0;
        b4.load           = 1'b0;
        b4.load_val       = '0;
        s10 = reset_state();
        s4  = reset_state();
        repeat (2) @(posedge clk);

        apply_stimulus(1, 0, 1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        repeat (12) apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 1, 0);
        repeat (4) apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 1, 3);
        repeat (5) apply_stimulus(0, 1, 1, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 1, 7);
        repeat (2) apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 1, 1, 0);
        repeat (12) apply_stimulus(0, 0, 1, 1, 0, 0);
        repeat (2) apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 1, 2);
        apply_stimulus(0, 0, 1, 0, 1, 12);
        repeat (2) apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 1, 2);
        apply_stimulus(1, 0, 1, 0, 0, 0);
        repeat (3) apply_stimulus(0, 0, 1, 0, 0, 0);

        up_keep = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) up_keep = !up_keep;
            apply_stimulus($urandom_range(49) == 0, $urandom_range(4) == 0, up_keep,
                           $urandom_range(2) == 0, $urandom_range(7) == 0,
                           int'($urandom_range(15)));
        end

        repeat (2) @(negedge clk);
        #1;
        if (q10.size() != 0 || q4.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", q10.size(), q4.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
